// File: rtl/ili9341_sprite_streamer.sv
// ----------------------------------------------------------------------------
// ili9341_sprite_streamer
//
// Streams one SCREEN_W x SCREEN_H frame of RGB565 pixels to an ILI9341
// controller, one word per valid/ready handshake, in raster order. Draws one
// sprite from a shared synchronous sprite ROM. The sprite is magnified by an
// integer SCALE and placed at a programmable position. Every pixel outside
// the sprite window is BG_COLOR. A sel change or a frame_req pulse queues
// exactly one redraw. A trigger that arrives mid-frame waits for the frame in
// flight to finish.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   sel        sprite table index drawn by the next frame
//   frame_req  one-cycle pulse that forces a redraw
//   cfg_we     sprite table write strobe; cfg_idx selects the entry
//   cfg_base   ROM address of source pixel (0,0)
//   cfg_w/h    source size in pixels (>= 1)
//   cfg_x/y    screen position of the top-left corner
//   mem_addr   ROM read address; mem_data returns one cycle later
//   pix_data   pixel word to the controller, qualified by pix_valid
//   pix_ready  controller accepts pix_data
//   pix_last   set on the final pixel of the frame
//   busy       a frame is in progress
// ----------------------------------------------------------------------------
module ili9341_sprite_streamer #(
    parameter int SCREEN_W    = 240,
    parameter int SCREEN_H    = 240,
    parameter int PIXEL_SIZE  = 16,
    parameter int SCALE       = 5,
    parameter int NUM_SPRITES = 14,
    parameter int MEM_DEPTH   = 7000,
    parameter logic [PIXEL_SIZE-1:0] BG_COLOR = 'h0010
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(NUM_SPRITES)-1:0] sel,
    input  logic                           frame_req,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
    input  logic [$clog2(MEM_DEPTH)-1:0]   cfg_base,
    input  logic [7:0]                     cfg_w,
    input  logic [7:0]                     cfg_h,
    input  logic [8:0]                     cfg_x,
    input  logic [8:0]                     cfg_y,
    output logic [$clog2(MEM_DEPTH)-1:0]   mem_addr,
    input  logic [PIXEL_SIZE-1:0]          mem_data,
    output logic [PIXEL_SIZE-1:0]          pix_data,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           pix_last,
    output logic                           busy
);

    localparam int SEL_W  = $clog2(NUM_SPRITES);
    localparam int ADDR_W = $clog2(MEM_DEPTH);
    // Coordinate width. It holds x0 + w*SCALE (at most 511 + 255*15) without overflow.
    localparam int CW     = 16;
    localparam int SW     = $clog2(SCALE + 1);

    localparam logic [CW-1:0] LAST_X  = CW'(SCREEN_W - 1);
    localparam logic [CW-1:0] LAST_Y  = CW'(SCREEN_H - 1);
    localparam logic [CW-1:0] SCALE_C = CW'(SCALE);
    localparam logic [SW-1:0] SUB_MAX = SW'(SCALE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} state_t;

    // ------------------------------------------------------------------
    // Sprite table
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] tbl_base [NUM_SPRITES];
    logic [7:0]        tbl_w    [NUM_SPRITES];
    logic [7:0]        tbl_h    [NUM_SPRITES];
    logic [8:0]        tbl_x    [NUM_SPRITES];
    logic [8:0]        tbl_y    [NUM_SPRITES];

    // NOTE: this is a small register table, not a RAM macro. It therefore takes a
    // reset, so that a frame drawn straight after reset sees defined entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                tbl_base[i] <= '0;
                tbl_w[i]    <= 8'd1;
                tbl_h[i]    <= 8'd1;
                tbl_x[i]    <= '0;
                tbl_y[i]    <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_SPRITES)) begin
            tbl_base[cfg_idx] <= cfg_base;
            tbl_w[cfg_idx]    <= cfg_w;
            tbl_h[cfg_idx]    <= cfg_h;
            tbl_x[cfg_idx]    <= cfg_x;
            tbl_y[cfg_idx]    <= cfg_y;
        end
    end

    // Entry selected by sel. An out-of-range sel reads as a cleared entry.
    logic              sel_ok;
    logic [ADDR_W-1:0] ent_base;
    logic [7:0]        ent_w, ent_h;
    logic [CW-1:0]     ent_x, ent_y, ent_win_w, ent_win_h;

    assign sel_ok    = int'(sel) < NUM_SPRITES;
    assign ent_base  = sel_ok ? tbl_base[sel] : '0;
    assign ent_w     = sel_ok ? tbl_w[sel]    : 8'd1;
    assign ent_h     = sel_ok ? tbl_h[sel]    : 8'd1;
    assign ent_x     = sel_ok ? CW'(tbl_x[sel]) : '0;
    assign ent_y     = sel_ok ? CW'(tbl_y[sel]) : '0;
    assign ent_win_w = CW'(ent_w) * SCALE_C;
    assign ent_win_h = CW'(ent_h) * SCALE_C;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t            state;
    logic              pending;
    logic [SEL_W-1:0]  sel_q;

    // Entry latched at frame start, so that table writes cannot disturb the frame in flight.
    logic [7:0]        lat_w;
    logic [CW-1:0]     lat_x0, lat_y0, win_w, win_h;

    // Current screen pixel, with scale sub-counters that replace a divider:
    // col_idx = (x-x0)/SCALE, and row_base = base + ((y-y0)/SCALE)*w.
    logic [CW-1:0]     x, y, col_idx;
    logic [SW-1:0]     col_sub, row_sub;
    logic [ADDR_W-1:0] row_base;

    function automatic logic in_win(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                    input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                                    input logic [CW-1:0] ww, input logic [CW-1:0] wh);
        return (px >= x0) && ((px - x0) < ww) && (py >= y0) && ((py - y0) < wh);
    endfunction

    // Raster successor of the current pixel, with its sub-counters.
    logic [CW-1:0]     adv_x, adv_y, adv_col_idx;
    logic [SW-1:0]     adv_col_sub, adv_row_sub;
    logic [ADDR_W-1:0] adv_row_base;

    // NOTE: every output of a combinational block gets a default first. A path
    // that leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        adv_x        = x + 1'b1;
        adv_y        = y;
        adv_col_sub  = col_sub;
        adv_col_idx  = col_idx;
        adv_row_sub  = row_sub;
        adv_row_base = row_base;
        if (x == LAST_X) begin
            adv_x       = '0;
            adv_y       = y + 1'b1;
            adv_col_sub = '0;
            adv_col_idx = '0;
            if (y >= lat_y0) begin
                if (row_sub == SUB_MAX) begin
                    adv_row_sub  = '0;
                    adv_row_base = row_base + ADDR_W'(lat_w);
                end else begin
                    adv_row_sub  = row_sub + 1'b1;
                end
            end
        end else if (x >= lat_x0) begin
            if (col_sub == SUB_MAX) begin
                adv_col_sub = '0;
                adv_col_idx = col_idx + 1'b1;
            end else begin
                adv_col_sub = col_sub + 1'b1;
            end
        end
    end

    logic              cur_inside, is_last, trigger;
    logic [ADDR_W-1:0] start_addr, adv_addr;

    assign cur_inside = in_win(x, y, lat_x0, lat_y0, win_w, win_h);
    assign is_last    = (x == LAST_X) && (y == LAST_Y);
    assign trigger    = frame_req || (sel != sel_q);
    assign start_addr = in_win('0, '0, ent_x, ent_y, ent_win_w, ent_win_h) ? ent_base : '0;
    assign adv_addr   = in_win(adv_x, adv_y, lat_x0, lat_y0, win_w, win_h)
                        ? adv_row_base + ADDR_W'(adv_col_idx) : '0;

    // mem_addr is registered on entry to FETCH. It is therefore valid for the
    // whole FETCH cycle, and the ROM word is available to WAIT. This keeps the
    // cadence at 3 cycles per pixel.
    // NOTE: all sequential state uses non-blocking assignments, so that every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 1'b1;
            sel_q     <= sel;      // no spurious trigger from the reset value of sel
            mem_addr  <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            lat_w     <= 8'd1;
            lat_x0    <= '0;
            lat_y0    <= '0;
            win_w     <= '0;
            win_h     <= '0;
            x         <= '0;
            y         <= '0;
            col_idx   <= '0;
            col_sub   <= '0;
            row_sub   <= '0;
            row_base  <= '0;
        end else begin
            sel_q   <= sel;
            // If a set and a clear arrive in the same cycle, the set wins.
            pending <= trigger || (pending && !(state == IDLE));

            case (state)
                IDLE: begin
                    if (pending) begin
                        lat_w    <= ent_w;
                        lat_x0   <= ent_x;
                        lat_y0   <= ent_y;
                        win_w    <= ent_win_w;
                        win_h    <= ent_win_h;
                        x        <= '0;
                        y        <= '0;
                        col_idx  <= '0;
                        col_sub  <= '0;
                        row_sub  <= '0;
                        row_base <= ent_base;
                        mem_addr <= start_addr;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    pix_data  <= cur_inside ? mem_data : BG_COLOR;
                    pix_valid <= 1'b1;
                    pix_last  <= is_last;
                    state     <= OUT;
                end
                OUT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        if (is_last) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            x        <= adv_x;
                            y        <= adv_y;
                            col_idx  <= adv_col_idx;
                            col_sub  <= adv_col_sub;
                            row_sub  <= adv_row_sub;
                            row_base <= adv_row_base;
                            mem_addr <= adv_addr;
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
